// File: rtl/uart_pkg.sv
// uart_pkg: shared UART datapath types and helpers.
// Holds the PISO state encodings and the bit-count width helper.
package uart_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_SHIFT = 1'b1;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_shifter.sv
// piso_shifter: parallel-in/serial-out shifter with one-entry hold register.
// Ports: clk, reset (async, high); data/load_valid/load_ready word load
// handshake; shift_en bit tick; q serial out; busy word active; done last-bit pulse.
module piso_shifter
  import uart_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit LSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             q,
  output logic             busy,
  output logic             done
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             q_q, q_d;
  logic             done_q, done_d;

  logic last;
  logic xfer;
  logic accept;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  always_comb begin
    last = (state_q == ST_SHIFT) && shift_en
        && (cnt_q == LAST);
    // Held word moves in either from idle or
    // right as the final bit period closes.
    xfer = hold_full_q
        && ((state_q == ST_IDLE) || last);
    load_ready = !hold_full_q || xfer;
    accept     = load_valid && load_ready;
  end

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (accept) begin
      hold_d      = data;
      hold_full_d = 1'b1;
    end else if (xfer) begin
      hold_full_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    done_d  = last;
    if (xfer) begin
      state_d = ST_SHIFT;
      sr_d    = hold_q;
      cnt_d   = '0;
      q_d     = first_bit(hold_q);
    end else if (last) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      q_d     = IDLE_LEVEL;
    end else if ((state_q == ST_SHIFT) && shift_en) begin
      cnt_d = cnt_q + 1'b1;
      if (LSB_FIRST) begin
        sr_d = {1'b0, sr_q[WIDTH-1:1]};
        q_d  = sr_q[1];
      end else begin
        sr_d = {sr_q[WIDTH-2:0], 1'b0};
        q_d  = sr_q[WIDTH-2];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sr_q        <= '0;
      cnt_q       <= '0;
      q_q         <= IDLE_LEVEL;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      q_q         <= q_d;
      done_q      <= done_d;
    end
  end

  assign q    = q_q;
  assign busy = (state_q == ST_SHIFT);
  assign done = done_q;

endmodule

// File: tb/tb_piso_shifter.sv
// tb_piso_shifter: directed plus random streams on LSB- and MSB-first
// shifters fed by identical stimulus, checked against a bit-order model.
module tb_piso_shifter;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data = 8'h00;
  logic       load_valid = 1'b0;
  logic       shift_en = 1'b0;

  logic rdy_l, q_l, busy_l, done_l;
  logic rdy_m, q_m, busy_m, done_m;

  int checks = 0;
  int failures = 0;
  logic [7:0] words [4];

  piso_shifter #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_lsb (
    .clk        (clk),
    .reset      (reset),
    .data       (data),
    .load_valid (load_valid),
    .load_ready (rdy_l),
    .shift_en   (shift_en),
    .q          (q_l),
    .busy       (busy_l),
    .done       (done_l)
  );

  piso_shifter #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_msb (
    .clk        (clk),
    .reset      (reset),
    .data       (data),
    .load_valid (load_valid),
    .load_ready (rdy_m),
    .shift_en   (shift_en),
    .q          (q_m),
    .busy       (busy_m),
    .done       (done_m)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic ebit(input logic [7:0] w,
                                input int i, input bit lsb);
    return lsb ? w[i] : w[7-i];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bits(input string tag, input logic [7:0] w,
                          input int i);
    chk({tag, "_lsb"}, q_l, ebit(w, i, 1'b1));
    chk({tag, "_msb"}, q_m, ebit(w, i, 1'b0));
  endtask

  task automatic chk_idle_out(input string tag);
    chk({tag, "_q_lsb"}, q_l, 1'b1);
    chk({tag, "_q_msb"}, q_m, 1'b1);
    chk({tag, "_busy_lsb"}, busy_l, 1'b0);
    chk({tag, "_busy_msb"}, busy_m, 1'b0);
  endtask

  task automatic stream(input int n, input int per, input bit stall);
    int guard;
    int idle;
    guard = 0;
    while (!rdy_l && guard < 50) begin
      tick();
      guard++;
    end
    chk("ready_idle", rdy_l, 1'b1);
    data = words[0];
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    data = 8'($urandom);
    tick();
    chk("busy_start_lsb", busy_l, 1'b1);
    chk("busy_start_msb", busy_m, 1'b1);
    chk_bits("first_bit", words[0], 0);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 8; i++) begin
        idle = per - 1 + ((stall && k == 0 && i == 3) ? 20 : 0);
        for (int c = 0; c < idle; c++) begin
          tick();
          chk_bits("hold_bit", words[k], i);
          chk("no_done_lsb", done_l, 1'b0);
          chk("no_done_msb", done_m, 1'b0);
        end
        shift_en = 1'b1;
        if (k + 1 < n && i == 0) begin
          load_valid = 1'b1;
          data = words[k+1];
        end
        tick();
        shift_en = 1'b0;
        if (k + 1 < n && i == 0) begin
          chk("ready_full_lsb", rdy_l, 1'b0);
          chk("ready_full_msb", rdy_m, 1'b0);
        end
        // Keep offering junk while the hold is full; it must be ignored.
        if (k + 1 < n && i <= 5) begin
          load_valid = 1'b1;
          data = 8'($urandom);
        end else begin
          load_valid = 1'b0;
        end
        if (i < 7) begin
          chk_bits("next_bit", words[k], i + 1);
          chk("mid_done_lsb", done_l, 1'b0);
          chk("mid_done_msb", done_m, 1'b0);
        end else begin
          chk("done_lsb", done_l, 1'b1);
          chk("done_msb", done_m, 1'b1);
          if (k + 1 < n) begin
            chk("gapless_busy", busy_l, 1'b1);
            chk_bits("gapless", words[k+1], 0);
          end else begin
            chk_idle_out("word_end");
          end
        end
      end
    end
    tick();
    chk("done_pulse_lsb", done_l, 1'b0);
    chk("done_pulse_msb", done_m, 1'b0);
    chk_idle_out("after");
  endtask

  initial begin
    #3;
    reset = 1'b1;
    #2;
    chk_idle_out("rst");
    chk("rst_done_lsb", done_l, 1'b0);
    chk("rst_done_msb", done_m, 1'b0);
    chk("rst_ready_lsb", rdy_l, 1'b1);
    chk("rst_ready_msb", rdy_m, 1'b1);
    #5;
    reset = 1'b0;
    clk_run = 1'b1;
    tick();
    tick();

    words[0] = 8'h99;
    stream(1, 4, 1'b0);

    words[0] = 8'h99;
    words[1] = 8'h61;
    stream(2, 4, 1'b1);

    words[0] = 8'h61;
    stream(1, 4, 1'b0);

    // Abort mid-word with a word sitting in hold.
    data = 8'h99;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    for (int b = 0; b < 3; b++) begin
      repeat (3) tick();
      shift_en = 1'b1;
      if (b == 0) begin
        load_valid = 1'b1;
        data = 8'h3C;
      end
      tick();
      shift_en = 1'b0;
      load_valid = 1'b0;
    end
    #2;
    reset = 1'b1;
    #1;
    chk_idle_out("abort");
    chk("abort_ready", rdy_l, 1'b1);
    chk("abort_done", done_l, 1'b0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();
    chk_idle_out("abort_release");

    words[0] = 8'hA5;
    stream(1, 4, 1'b0);

    for (int j = 0; j < 3; j++) words[j] = 8'($urandom);
    stream(3, 1, 1'b0);

    for (int j = 0; j < 2; j++) words[j] = 8'($urandom);
    stream(2, 3, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
